// File: rtl/mp_add_if.sv
// Bundle of the request, response and shared-CLA-slice signals of the
// multi-precision add/subtract controller. The slave side is the controller;
// the master side is whatever drives requests, consumes results and hosts
// the shared 8-bit slice.
interface mp_add_if #(
    parameter int WORDS = 4
);
    localparam int W = 8 * WORDS;

    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic          req_cin;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;

    logic [7:0]    cla_a;
    logic [7:0]    cla_b;
    logic          cla_cin;
    logic [7:0]    cla_sum;
    logic          cla_cout;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_carry;
    logic          rsp_ovf;
    logic          rsp_zero;

    logic          busy;

    modport slave (
        input  req_valid, req_op, req_cin, req_a, req_b,
        output req_ready,
        output cla_a, cla_b, cla_cin,
        input  cla_sum, cla_cout,
        output rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_op, req_cin, req_a, req_b,
        input  req_ready,
        input  cla_a, cla_b, cla_cin,
        output cla_sum, cla_cout,
        input  rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer. Time-shares one external 8-bit
// carry-lookahead slice: operands are latched, fed through the slice one
// byte per cycle (LSB first) with the carry chained through a register,
// and the assembled result plus carry/overflow/zero flags are held until
// the consumer takes them.
module mp_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    mp_add_if.slave bus
);
    localparam int W     = 8 * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       result_q, result_d;
    logic               rcarry_q, rcarry_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    // State register and datapath flops; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            rcarry_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            rcarry_q <= rcarry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state logic: accept, step one byte per cycle, then hold the result.
    // The carry register is preloaded with the operation's initial carry at
    // acceptance, so in RUN the slice carry-in is always the carry register.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        rcarry_d = rcarry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    a_d   = bus.req_a;
                    b_d   = bus.req_op[1] ? ~bus.req_b : bus.req_b;
                    idx_d = '0;
                    case (bus.req_op)
                        2'b00:   carry_d = 1'b0;
                        2'b01:   carry_d = bus.req_cin;
                        2'b10:   carry_d = 1'b1;
                        default: carry_d = bus.req_cin;
                    endcase
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[{idx_q, 3'b000} +: 8] = bus.cla_sum;
                carry_d = bus.cla_cout;
                if (idx_q == LAST_IDX) begin
                    rcarry_d = bus.cla_cout;
                    ovf_d    = (a_q[W-1] == b_q[W-1]) & (result_d[W-1] != a_q[W-1]);
                    zero_d   = ~|result_d;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode straight from the state register.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);

    // Slice operands are forced to zero whenever the slice is not in use.
    assign bus.cla_a   = (state_q == RUN) ? a_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign bus.cla_b   = (state_q == RUN) ? b_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign bus.cla_cin = (state_q == RUN) ? carry_q : 1'b0;

    assign bus.rsp_result = result_q;
    assign bus.rsp_carry  = rcarry_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.rsp_zero   = zero_q;
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer with WORDS=4. The shared CLA
// slice is modelled behaviourally; results are predicted with plain
// 64-bit arithmetic on the full operands.
module tb_mp_add_sequencer;
    localparam int WORDS = 4;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    logic [1:0]  curOp;
    logic        curCin;
    logic [31:0] curA;
    logic [31:0] curB;

    logic [31:0] capB;
    logic [3:0]  capCin;
    logic [31:0] gotResult;
    logic        gotCarry;
    logic        gotOvf;
    logic        gotZero;
    int          validSeen;

    mp_add_if #(.WORDS(WORDS)) bus ();

    // Behavioural 8-bit slice shared with the controller.
    assign {bus.cla_cout, bus.cla_sum} = {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + 9'(bus.cla_cin);

    mp_add_sequencer #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {ovf, zero, carry, result} from integer arithmetic.
    function automatic logic [34:0] refModel(input logic [1:0] op, input logic cin,
                                             input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, full, strue;
        longint c;
        logic [31:0] res;
        logic carry, ovf;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[1] == 1'b0) begin
            c     = (op == 2'b01) ? longint'(cin) : 0;
            full  = ua + ub + c;
            carry = (full >= 64'sd4294967296);
            strue = sa + sb + c;
        end else begin
            c     = (op == 2'b10) ? 0 : longint'(!cin);
            full  = ua - ub - c;
            carry = (ua >= ub + c);
            strue = sa - sb - c;
        end
        res = full[31:0];
        ovf = (strue > 64'sd2147483647) || (strue < -64'sd2147483648);
        return {ovf, (res == 32'h0), carry, res};
    endfunction

    // Carry into byte i: the carry out of the low 8*i bits of the addition
    // the slice is performing (B complemented for subtraction).
    function automatic logic refCin(input int i);
        longint mask, lowSum, bb, c0;
        bb   = longint'(curOp[1] ? ~curB : curB);
        c0   = (curOp == 2'b00) ? 0 : (curOp == 2'b10) ? 1 : longint'(curCin);
        mask = (64'sd1 <<< (8 * i)) - 1;
        lowSum = (longint'(curA) & mask) + (bb & mask) + c0;
        return lowSum[8*i];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request and wait (bounded) until it is accepted.
    task automatic applyStimulus(input logic [1:0] op, input logic cin,
                                 input logic [31:0] a, input logic [31:0] b);
        curOp  = op;
        curCin = cin;
        curA   = a;
        curB   = b;
        @(negedge clk);
        for (int t = 0; t < 20 && !bus.req_ready; t++) @(negedge clk);
        if (!bus.req_ready) checkOutput("req_ready_wait", 64'(bus.req_ready), 64'd1);
        bus.req_op    = op;
        bus.req_cin   = cin;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
    endtask

    // Follow the four RUN cycles after acceptance, then check the response.
    task automatic checkRun();
        logic [34:0] exp;
        logic [31:0] expB;
        expB = curOp[1] ? ~curB : curB;
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            checkOutput($sformatf("busy_b%0d", i), 64'(bus.busy), 64'd1);
            checkOutput($sformatf("req_ready_b%0d", i), 64'(bus.req_ready), 64'd0);
            checkOutput($sformatf("rsp_valid_b%0d", i), 64'(bus.rsp_valid), 64'd0);
            checkOutput($sformatf("cla_a_b%0d", i), 64'(bus.cla_a), 64'(curA[8*i +: 8]));
            checkOutput($sformatf("cla_b_b%0d", i), 64'(bus.cla_b), 64'(expB[8*i +: 8]));
            checkOutput($sformatf("cla_cin_b%0d", i), 64'(bus.cla_cin), 64'(refCin(i)));
            capB[8*i +: 8] = bus.cla_b;
            capCin[i]      = bus.cla_cin;
        end
        @(negedge clk);
        exp = refModel(curOp, curCin, curA, curB);
        checkOutput("rsp_valid_done", 64'(bus.rsp_valid), 64'd1);
        checkOutput("rsp_result", 64'(bus.rsp_result), 64'(exp[31:0]));
        checkOutput("rsp_carry", 64'(bus.rsp_carry), 64'(exp[32]));
        checkOutput("rsp_zero", 64'(bus.rsp_zero), 64'(exp[33]));
        checkOutput("rsp_ovf", 64'(bus.rsp_ovf), 64'(exp[34]));
        gotResult = bus.rsp_result;
        gotCarry  = bus.rsp_carry;
        gotOvf    = bus.rsp_ovf;
        gotZero   = bus.rsp_zero;
    endtask

    // Keep rsp_ready low and confirm the response holds still.
    task automatic holdRsp(input int cycles);
        for (int h = 0; h < cycles; h++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("hold_req_ready", 64'(bus.req_ready), 64'd0);
            checkOutput("hold_result", 64'(bus.rsp_result), 64'(gotResult));
            checkOutput("hold_flags", 64'({bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero}),
                        64'({gotCarry, gotOvf, gotZero}));
        end
    endtask

    task automatic releaseRsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_hs", 64'(bus.rsp_valid), 64'd0);
        checkOutput("req_ready_after_hs", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic runOp(input logic [1:0] op, input logic cin,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
        applyStimulus(op, cin, a, b);
        checkRun();
        holdRsp(hold);
        releaseRsp();
    endtask

    // Directed sequence followed by randomized operations.
    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_cin   = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_result", 64'(bus.rsp_result), 64'd0);
        checkOutput("rst_flags", 64'({bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero}), 64'd0);
        checkOutput("rst_cla", 64'({bus.cla_a, bus.cla_b, bus.cla_cin}), 64'd0);
        rst_n = 1'b1;

        $display("[TB] ADD carry ripple through all bytes");
        runOp(2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        checkOutput("t1_result", 64'(gotResult), 64'h0);
        checkOutput("t1_flags", 64'({gotCarry, gotZero, gotOvf}), 64'b110);
        checkOutput("t1_cin_seq", 64'(capCin), 64'b1110);

        $display("[TB] ADD signed overflow");
        runOp(2'b00, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        checkOutput("t2_result", 64'(gotResult), 64'h8000_0000);
        checkOutput("t2_flags", 64'({gotCarry, gotZero, gotOvf}), 64'b001);

        $display("[TB] SUB with borrow");
        runOp(2'b10, 1'b0, 32'h0000_0000, 32'h0000_0001, 0);
        checkOutput("t3_result", 64'(gotResult), 64'hFFFF_FFFF);
        checkOutput("t3_flags", 64'({gotCarry, gotOvf}), 64'b00);
        checkOutput("t3_cla_b", 64'(capB), 64'hFFFF_FFFE);

        $display("[TB] ADC then SBB");
        runOp(2'b01, 1'b1, 32'h1234_5678, 32'h1111_1111, 0);
        checkOutput("t4_result", 64'(gotResult), 64'h2345_678A);
        checkOutput("t4_carry", 64'(gotCarry), 64'd0);
        runOp(2'b11, 1'b0, 32'h0000_0010, 32'h0000_0001, 0);
        checkOutput("t5_result", 64'(gotResult), 64'h0000_000E);
        checkOutput("t5_carry", 64'(gotCarry), 64'd1);

        $display("[TB] backpressure with next request waiting");
        applyStimulus(2'b00, 1'b0, 32'hCAFE_0001, 32'h0101_0101);
        checkRun();
        curOp  = 2'b10;
        curCin = 1'b0;
        curA   = 32'h0000_1000;
        curB   = 32'h0000_2000;
        bus.req_op    = curOp;
        bus.req_cin   = curCin;
        bus.req_a     = curA;
        bus.req_b     = curB;
        bus.req_valid = 1'b1;
        holdRsp(3);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("bp_rsp_valid_low", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        checkOutput("bp_idle_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("bp_idle_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkRun();
        releaseRsp();

        $display("[TB] reset during RUN byte 2");
        applyStimulus(2'b00, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_cla_a_b2", 64'(bus.cla_a), 64'h34);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("mid_busy", 64'(bus.busy), 64'd0);
        checkOutput("mid_result", 64'(bus.rsp_result), 64'd0);
        checkOutput("mid_flags", 64'({bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero}), 64'd0);
        checkOutput("mid_cla", 64'({bus.cla_a, bus.cla_b, bus.cla_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) validSeen++;
        end
        checkOutput("mid_no_rsp_pulse", 64'(validSeen), 64'd0);
        runOp(2'b00, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1);
        checkOutput("post_rst_result", 64'(gotResult), 64'h0000_0100);

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            runOp(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
Multi-precision add/subtract controller that time-shares one external 8-bit carry-lookahead adder slice to process WORDS-byte operands, least-significant byte first, one byte per cycle. It latches a request, drives the slice byte by byte while chaining the registered carry, then assembles the result and flags. It sits between an operand-issuing requester and the shared 8-bit CLA datapath.

Parameters:
WORDS, 4, number of 8-bit limbs per operand; operand width W = 8*WORDS; legal range 2..16

Ports:
clk        in   1    single clock, rising edge
rst_n      in   1    asynchronous active-low reset
req_valid  in   1    request present
req_ready  out  1    controller can accept a request
req_op     in   2    00 ADD, 01 ADC, 10 SUB, 11 SBB
req_cin    in   1    carry-in; used by ADC and SBB
req_a      in   W    operand A
req_b      in   W    operand B
cla_a      out  8    byte to slice input A
cla_b      out  8    byte to slice input B (already inverted for SUB/SBB)
cla_cin    out  1    slice carry-in
cla_sum    in   8    slice sum, combinational from cla_a/cla_b/cla_cin
cla_cout   in   1    slice carry-out, combinational
rsp_valid  out  1    result valid
rsp_ready  in   1    consumer accepts result
rsp_result out  W    sum/difference
rsp_carry  out  1    final carry-out (for SUB/SBB: 1 = no borrow)
rsp_ovf    out  1    signed overflow
rsp_zero   out  1    rsp_result == 0
busy       out  1    high in RUN or DONE

Behaviour:
- Reset (async, rst_n low): state IDLE, index 0, carry register 0, all registered operands/result cleared; req_ready=1, rsp_valid=0, busy=0, rsp_result=0, rsp_carry/ovf/zero=0. cla_a/cla_b/cla_cin=0 outside RUN.
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid & req_ready at an edge: latch A, B' (B for ADD/ADC, ~B for SUB/SBB), initial carry (ADD 0, ADC req_cin, SUB 1, SBB req_cin), index<=0, go to RUN. Inputs are ignored after acceptance.
- RUN: req_ready=0. cla_a = A[8i+7:8i], cla_b = B'[8i+7:8i], cla_cin = initial carry for i=0, else carry register. Each RUN edge: result byte i <= cla_sum, carry register <= cla_cout, index increments. On the edge where i = WORDS-1, go to DONE.
- Latency: with acceptance at edge k, RUN occupies the WORDS cycles after it and rsp_valid rises after edge k+WORDS. For WORDS=4 that is 4 cycles, so rsp_valid is first sampled high at edge k+5.
- DONE: rsp_valid=1. rsp_carry = final carry register. rsp_ovf = (A[W-1]==B'[W-1]) & (result[W-1]!=A[W-1]). rsp_zero = ~|result. All rsp_* are registered and hold stable while rsp_ready=0, for any number of cycles. On rsp_valid & rsp_ready: go to IDLE, rsp_valid=0.
- No overlap: req_ready=0 in RUN and DONE. The earliest next acceptance is the edge after the response handshake. A req_valid held high across DONE is accepted in the following IDLE cycle.
- rsp_result keeps its last value in IDLE. It is overwritten byte by byte during the next RUN and is valid only while rsp_valid=1.
- Reset mid-RUN or mid-DONE: immediate return to the reset state. The partial result is discarded and no rsp_valid pulse occurs.
- Index width is clog2(WORDS). Index must not wrap within an operation.

Test Plan:
- ADD, A=0xFFFFFFFF, B=0x00000001 (WORDS=4) -> result 0x00000000, carry 1, zero 1, ovf 0. rsp_valid exactly 4 cycles after the accept edge. cla_cin sequence 0,1,1,1.
- ADD, A=0x7FFFFFFF, B=0x00000001 -> result 0x80000000, carry 0, ovf 1, zero 0.
- SUB, A=0x00000000, B=0x00000001 -> result 0xFFFFFFFF, carry 0 (borrow), ovf 0. cla_b bytes observed as 0xFE,0xFF,0xFF,0xFF.
- ADC cin=1, A=0x12345678, B=0x11111111 -> 0x2345678A, carry 0. Then SBB cin=0, A=0x00000010, B=0x00000001 -> 0x0000000E, carry 1.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE -> rsp_* stable and req_ready=0 throughout. With req_valid held high, the next request is accepted exactly one cycle after the rsp handshake.
- Assert rst_n low during RUN byte index 2 -> all outputs take reset values immediately. No rsp_valid pulse follows. A fresh request after release completes correctly.
